// File: rtl/score_sequencer.sv
// Award sequencer for the BCD score counter: round-robin grants, N points -> N count_en pulses, clears, overflow.
// Optional SCORE_SATURATE_EN: stop issuing pulses at 9999 instead of letting the counter wrap.
module score_sequencer #(
    parameter int PTS_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [PTS_W-1:0] pts0,
    output logic             ack0,
    input  logic             req1,
    input  logic [PTS_W-1:0] pts1,
    output logic             ack1,
    input  logic             clear_req,
    input  logic             hold,
    input  logic [15:0]      digits,
    input  logic             cnt_carry,
    output logic             count_en,
    output logic             counter_clear,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, COUNT, CLEAR} state_t;

    state_t           state_q;
    logic [PTS_W-1:0] remaining_q;
    logic             rr_ptr_q;
    logic             ack0_q, ack1_q, count_en_q, counter_clear_q, busy_q, overflow_q;

    logic             grant0_d, grant1_d;
    logic [PTS_W-1:0] grant_pts_d;
    logic             sat_hit;

    always_comb begin
        grant0_d = req0;
        grant1_d = req1;
        if (req0 && req1) begin
            grant0_d = !rr_ptr_q;
            grant1_d = rr_ptr_q;
        end
        grant_pts_d = grant1_d ? pts1 : pts0;
    end

`ifdef SCORE_SATURATE_EN
    // digits lags count_en by one edge, so a pulse in flight at 9998 already reaches 9999.
    assign sat_hit = (digits == 16'h9999) || (count_en_q && (digits == 16'h9998));
`else
    logic unused_digits;
    assign unused_digits = ^digits;
    assign sat_hit       = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            rr_ptr_q        <= 1'b0;
            ack0_q          <= 1'b0;
            ack1_q          <= 1'b0;
            count_en_q      <= 1'b0;
            counter_clear_q <= 1'b0;
            busy_q          <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            ack0_q          <= 1'b0;
            ack1_q          <= 1'b0;
            counter_clear_q <= 1'b0;
            if (cnt_carry) overflow_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    count_en_q <= 1'b0;
                    if (clear_req) begin
                        state_q         <= CLEAR;
                        busy_q          <= 1'b1;
                        counter_clear_q <= 1'b1;
                        overflow_q      <= 1'b0;
                    end else if (grant0_d || grant1_d) begin
                        ack0_q      <= grant0_d;
                        ack1_q      <= grant1_d;
                        remaining_q <= grant_pts_d;
                        if (req0 && req1) rr_ptr_q <= ~rr_ptr_q;
                        if (grant_pts_d != '0) begin
                            state_q <= COUNT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (clear_req) begin
                        // Aborted award stays acked; its remaining points are dropped.
                        state_q         <= CLEAR;
                        remaining_q     <= '0;
                        count_en_q      <= 1'b0;
                        counter_clear_q <= 1'b1;
                        overflow_q      <= 1'b0;
                    end else if (sat_hit) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        remaining_q <= '0;
                        count_en_q  <= 1'b0;
                        overflow_q  <= 1'b1;
                    end else if (remaining_q == '0) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        count_en_q <= 1'b0;
                    end else if (hold) begin
                        count_en_q <= 1'b0;
                    end else begin
                        count_en_q  <= 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                    end
                end
                CLEAR: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    count_en_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    count_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack0          = ack0_q;
    assign ack1          = ack1_q;
    assign count_en      = count_en_q;
    assign counter_clear = counter_clear_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer with a behavioural 4-digit BCD counter attached to count_en/counter_clear.
module tb_score_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  pts0 = 4'd0, pts1 = 4'd0;
    logic        ack0, ack1;
    logic        clear_req = 1'b0, hold = 1'b0;
    logic [15:0] digits;
    logic        cnt_carry;
    logic        count_en, counter_clear, busy, overflow;
    logic        load_en = 1'b0;
    logic [15:0] load_val = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;

    score_sequencer #(.PTS_W(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .pts0(pts0), .ack0(ack0),
        .req1(req1), .pts1(pts1), .ack1(ack1),
        .clear_req(clear_req), .hold(hold),
        .digits(digits), .cnt_carry(cnt_carry),
        .count_en(count_en), .counter_clear(counter_clear),
        .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign cnt_carry = count_en && (digits == 16'h9999);

    always @(posedge clock or negedge reset) begin
        if (!reset)             digits <= 16'h0000;
        else if (counter_clear) digits <= 16'h0000;
        else if (load_en)       digits <= load_val;
        else if (count_en)      digits <= bcd_inc(digits);
    end

    task automatic wait_ack(output logic a0, output logic a1, output logic to);
        to = 1'b1;
        a0 = 1'b0;
        a1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ack0 || ack1) begin
                a0 = ack0;
                a1 = ack1;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic preload(input logic [15:0] v);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clock);
        load_en  = 1'b0;
    endtask

    task automatic test_reset();
        logic a0, a1, to;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if ({ack0, ack1, count_en, counter_clear, busy, overflow} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_idle: outputs=%b expected 000000", {ack0, ack1, count_en, counter_clear, busy, overflow});
        end
        reset = 1'b1;
        req0 = 1'b1; pts0 = 4'd5;
        wait_ack(a0, a1, to);
        req0 = 1'b0;
        n_checks++;
        if (to || a0 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ack: ack0=%b timeout=%b expected ack0=1", a0, to);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ack0, ack1, count_en, counter_clear, busy, overflow} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_async: outputs=%b expected 000000", {ack0, ack1, count_en, counter_clear, busy, overflow});
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_after: count_en=%b busy=%b expected 0 0", count_en, busy);
            end
        end
    endtask

    task automatic test_single();
        logic a0, a1, to;
        req0 = 1'b1; pts0 = 4'd3;
        wait_ack(a0, a1, to);
        req0 = 1'b0;
        n_checks++;
        if (to || a0 !== 1'b1 || a1 !== 1'b0 || count_en !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_ack: ack0=%b ack1=%b count_en=%b busy=%b timeout=%b expected 1 0 0 1", a0, a1, count_en, busy, to);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b1 || ack0 !== 1'b0) begin
                n_errors++;
                $display("FAIL single_pulse%0d: count_en=%b ack0=%b expected 1 0", k, count_en, ack0);
            end
        end
        @(negedge clock);
        n_checks++;
        if (count_en !== 1'b0 || busy !== 1'b0 || digits !== 16'h0003) begin
            n_errors++;
            $display("FAIL single_done: count_en=%b busy=%b digits=%h expected 0 0 0003", count_en, busy, digits);
        end
    endtask

    task automatic test_contention();
        logic a0, a1, to;
        for (int round = 0; round < 2; round++) begin
            req0 = 1'b1; pts0 = 4'd2;
            req1 = 1'b1; pts1 = 4'd4;
            for (int g = 0; g < 2; g++) begin
                // round 0 grants req0 then req1; round 1 starts from req1
                wait_ack(a0, a1, to);
                n_checks++;
                if (to || a0 !== ((round == 0) == (g == 0)) || a1 !== ((round == 0) != (g == 0))) begin
                    n_errors++;
                    $display("FAIL contention_r%0d_g%0d: ack0=%b ack1=%b timeout=%b expected ack0=%b ack1=%b",
                             round, g, a0, a1, to, (round == 0) == (g == 0), (round == 0) != (g == 0));
                end
                if (a0) req0 = 1'b0;
                if (a1) req1 = 1'b0;
                for (int k = 0; k < (a0 ? 2 : 4); k++) begin
                    @(negedge clock);
                    n_checks++;
                    if (count_en !== 1'b1) begin
                        n_errors++;
                        $display("FAIL contention_pulse r%0d g%0d k%0d: count_en=%b expected 1", round, g, k, count_en);
                    end
                end
                @(negedge clock);
                n_checks++;
                if (count_en !== 1'b0 || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL contention_end r%0d g%0d: count_en=%b busy=%b expected 0 0", round, g, count_en, busy);
                end
            end
            n_checks++;
            if (digits !== ((round == 0) ? 16'h0009 : 16'h0015)) begin
                n_errors++;
                $display("FAIL contention_digits r%0d: digits=%h expected %h", round, digits, (round == 0) ? 16'h0009 : 16'h0015);
            end
        end
    endtask

    task automatic test_hold_zero();
        logic a0, a1, to;
        req1 = 1'b1; pts1 = 4'd4;
        wait_ack(a0, a1, to);
        req1 = 1'b0;
        n_checks++;
        if (to || a1 !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_ack: ack1=%b timeout=%b expected 1", a1, to);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b1) begin
                n_errors++;
                $display("FAIL hold_pre%0d: count_en=%b expected 1", k, count_en);
            end
        end
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL hold_paused%0d: count_en=%b busy=%b expected 0 1", k, count_en, busy);
            end
        end
        hold = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b1) begin
                n_errors++;
                $display("FAIL hold_post%0d: count_en=%b expected 1", k, count_en);
            end
        end
        @(negedge clock);
        n_checks++;
        if (count_en !== 1'b0 || busy !== 1'b0 || digits !== 16'h0019) begin
            n_errors++;
            $display("FAIL hold_done: count_en=%b busy=%b digits=%h expected 0 0 0019", count_en, busy, digits);
        end

        req0 = 1'b1; pts0 = 4'd0;
        wait_ack(a0, a1, to);
        req0 = 1'b0;
        n_checks++;
        if (to || a0 !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_ack: ack0=%b busy=%b timeout=%b expected 1 0", a0, busy, to);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b0 || ack0 !== 1'b0) begin
                n_errors++;
                $display("FAIL zero_idle%0d: count_en=%b ack0=%b expected 0 0", k, count_en, ack0);
            end
        end
        n_checks++;
        if (digits !== 16'h0019) begin
            n_errors++;
            $display("FAIL zero_digits: digits=%h expected 0019", digits);
        end
    endtask

    task automatic test_overflow();
        logic a0, a1, to;
        int   exp_pulses;
        logic [15:0] exp_digits;
`ifdef SCORE_SATURATE_EN
        exp_pulses = 1;
        exp_digits = 16'h9999;
`else
        exp_pulses = 3;
        exp_digits = 16'h0001;
`endif
        preload(16'h9998);
        n_checks++;
        if (digits !== 16'h9998 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_preload: digits=%h overflow=%b expected 9998 0", digits, overflow);
        end
        req0 = 1'b1; pts0 = 4'd3;
        wait_ack(a0, a1, to);
        req0 = 1'b0;
        n_checks++;
        if (to || a0 !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_ack: ack0=%b timeout=%b expected 1", a0, to);
        end
        for (int k = 0; k < exp_pulses; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b1) begin
                n_errors++;
                $display("FAIL ovf_pulse%0d: count_en=%b expected 1", k, count_en);
            end
        end
        @(negedge clock);
        n_checks++;
        if (count_en !== 1'b0 || busy !== 1'b0 || digits !== exp_digits || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_done: count_en=%b busy=%b digits=%h overflow=%b expected 0 0 %h 1",
                     count_en, busy, digits, overflow, exp_digits);
        end
`ifdef SCORE_SATURATE_EN
        req1 = 1'b1; pts1 = 4'd2;
        wait_ack(a0, a1, to);
        req1 = 1'b0;
        n_checks++;
        if (to || a1 !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_ack: ack1=%b timeout=%b expected 1", a1, to);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b0 || digits !== 16'h9999) begin
                n_errors++;
                $display("FAIL sat_nopulse%0d: count_en=%b digits=%h expected 0 9999", k, count_en, digits);
            end
        end
`endif
    endtask

    task automatic test_clear();
        logic a0, a1, to;
        preload(16'h0000);
        req0 = 1'b1; pts0 = 4'd9;
        wait_ack(a0, a1, to);
        req0 = 1'b0;
        n_checks++;
        if (to || a0 !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_ack: ack0=%b timeout=%b expected 1", a0, to);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b1) begin
                n_errors++;
                $display("FAIL clear_pre%0d: count_en=%b expected 1", k, count_en);
            end
        end
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        n_checks++;
        if (count_en !== 1'b0 || counter_clear !== 1'b1 || overflow !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_pulse: count_en=%b counter_clear=%b overflow=%b busy=%b expected 0 1 0 1",
                     count_en, counter_clear, overflow, busy);
        end
        @(negedge clock);
        n_checks++;
        if (counter_clear !== 1'b0 || busy !== 1'b0 || digits !== 16'h0000 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_done: counter_clear=%b busy=%b digits=%h overflow=%b expected 0 0 0000 0",
                     counter_clear, busy, digits, overflow);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if (count_en !== 1'b0 || counter_clear !== 1'b0) begin
                n_errors++;
                $display("FAIL clear_noreissue%0d: count_en=%b counter_clear=%b expected 0 0", k, count_en, counter_clear);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_hold_zero();
        test_overflow();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Controller that sits in front of the 4-digit BCD score counter.
- Accepts point-award requests from two requesters (e.g. player shell hit, bonus pickup) and arbitrates between them round-robin.
- Converts each award of N points into N single-cycle count_en pulses on the counter's enable input.
- Issues counter clears and tracks overflow (wrap past 9999).

Parameters:
- PTS_W, 4, width of each requester's point field; max award per request is 2^PTS_W-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 award request, level; held until ack0.
- pts0  input  PTS_W  requester 0 point count; stable while req0 is high.
- ack0  output  1  one-cycle pulse; requester 0 award accepted.
- req1  input  1  requester 1 award request, level.
- pts1  input  PTS_W  requester 1 point count.
- ack1  output  1  one-cycle pulse; requester 1 award accepted.
- clear_req  input  1  one-cycle pulse; zero the score.
- hold  input  1  pause pulse issue (game paused); state is kept.
- digits  input  16  counter value {V3,V2,V1,V0}, BCD, registered in the counter.
- cnt_carry  input  1  counter carry_out (high on the edge that wraps 9999 to 0000).
- count_en  output  1  enable to the counter; one point per high cycle.
- counter_clear  output  1  one-cycle clear pulse to the counter's reset input.
- busy  output  1  high in any state other than IDLE.
- overflow  output  1  sticky; score has wrapped or saturated.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, remaining=0, rr_ptr=0.
  - All outputs 0: ack0/1, count_en, counter_clear, busy, overflow.
- States: IDLE, COUNT, CLEAR.
- IDLE priority, evaluated each cycle:
  - clear_req wins over all requests: go to CLEAR.
  - Otherwise, if exactly one req is high, grant it.
  - If both are high, grant the requester rr_ptr points to, then set rr_ptr to the other requester.
- Grant:
  - Pulse ack for the granted requester in the same cycle (registered, seen the cycle after req is sampled).
  - Latch remaining=pts.
  - If pts=0: ack only, no pulses, stay IDLE.
  - Otherwise go to COUNT.
- COUNT:
  - While remaining>0 and hold=0: count_en=1 and remaining decrements by 1 each cycle.
  - When hold=1: count_en=0, remaining frozen.
  - Transition to IDLE in the cycle after the final pulse.
  - N points produce exactly N count_en cycles; the first pulse comes the cycle after ack.
- Requests arriving during COUNT or CLEAR wait; they are not acked until IDLE.
- clear_req during COUNT:
  - Abort the award: remaining is discarded and count_en drops next cycle.
  - Go to CLEAR.
  - The aborted award stays acked and is not re-issued.
- clear_req is a pulse; it is not remembered if it arrives while already in CLEAR.
- CLEAR:
  - counter_clear=1 for exactly one cycle; overflow cleared in the same cycle.
  - Return to IDLE.
  - hold does not block CLEAR.
- Overflow: cnt_carry=1 on any cycle sets overflow; it stays set until CLEAR or reset.
- count_en is never high in IDLE or CLEAR.
- Mid-operation reset: everything returns to reset values immediately; partial awards are lost.

Optional Feature:
- Macro SCORE_SATURATE_EN.
- Defined:
  - In COUNT, if digits==16'h9999, suppress count_en, set overflow, and discard remaining.
  - Return to IDLE next cycle. The score holds at 9999 and never wraps.
  - Further grants still ack normally but issue no pulses while digits==16'h9999.
- Not defined:
  - The counter wraps 9999 to 0000.
  - overflow is set only from cnt_carry; digits is unused.

Test Plan:
- Reset: hold reset=0 mid-COUNT with pts0=5 -> all outputs 0 immediately; after release, busy=0 and no count_en.
- Single award: req0=1, pts0=3 -> ack0 pulse, then count_en high 3 consecutive cycles, busy falls the cycle after; digits go 0000 to 0003.
- Contention: req0 and req1 both high, pts0=2, pts1=4 -> ack0 first with 2 pulses, then ack1 with 4 pulses. Repeating the contention grants req1 first.
- Hold and zero: pts1=4 with hold=1 for 3 cycles after the 2nd pulse -> still exactly 4 pulses total. Separately, pts0=0 -> ack0, no count_en.
- Clear mid-award: pts0=9, clear_req after the 2nd pulse -> count_en drops, counter_clear pulses once, digits=0000, overflow=0.
- Overflow: preload digits to 9998, award 3 points.
  - Without the macro: cnt_carry fires, digits=0001, overflow=1.
  - With SCORE_SATURATE_EN: 1 pulse only, digits=9999, overflow=1.
